// File: rtl/neuro_nav_pkg.sv
// Shared constants and helpers for the neuro_odom_nch spiking odometry peripheral.
package neuro_nav_pkg;

  // Register byte offsets
  localparam logic [5:0] AddrCmd       = 6'h00;
  localparam logic [5:0] AddrCtrl      = 6'h04;
  localparam logic [5:0] AddrThresh    = 6'h08;
  localparam logic [5:0] AddrLimit     = 6'h0C;
  localparam logic [5:0] AddrIntStatus = 6'h10;
  localparam logic [5:0] AddrIntMask   = 6'h14;
  localparam logic [5:0] AddrPosBase   = 6'h20;

  // CTRL bit indices
  localparam int CtrlEnable  = 0;
  localparam int CtrlWrap    = 1;
  localparam int CtrlSpikeEn = 2;
  localparam int CtrlClear   = 3;

  // INT_STATUS bit indices
  localparam int IntLimitLsb = 0;
  localparam int IntOverflow = 8;

  // Command word fields
  localparam int CmdDeltaMsb = 15;
  localparam int CmdAxisLsb  = 16;
  localparam int CmdAxisMsb  = 17;
  localparam int CmdW        = 18;

  // data_write_n encodings
  localparam logic [1:0] WrByte = 2'b00;
  localparam logic [1:0] WrHalf = 2'b01;
  localparam logic [1:0] WrWord = 2'b10;
  localparam logic [1:0] WrNone = 2'b11;

  // Signed add clamped to the range of a w-bit two's complement value.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    logic signed [31:0] hi, lo, s;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    s  = a + b;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  // Merge bus write data into an old value according to the access size.
  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] din,
                                         input logic [1:0] wn);
    case (wn)
      WrByte:  return {old[31:8], din[7:0]};
      WrHalf:  return {old[31:16], din[15:0]};
      WrWord:  return din;
      default: return old;
    endcase
  endfunction

endpackage

// File: rtl/neuro_odom_nch_if.sv
// TinyQV-style register bus bundle for neuro_odom_nch.
interface neuro_odom_nch_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready, user_interrupt
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready, user_interrupt
  );
endinterface

// File: rtl/neuro_spike_sync.sv
// Two-flop synchroniser per pin followed by a rising-edge pulse detector.
module neuro_spike_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] rise
);
  logic [Width-1:0] meta_q, sync_q, prev_q;

  // Synchroniser chain plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
endmodule

// File: rtl/neuro_odom_nch.sv
// Multi-axis spiking odometry peripheral: spike and command-FIFO integration into
// saturating/wrapping positions, threshold outputs and limit/overflow interrupts.
module neuro_odom_nch
  import neuro_nav_pkg::*;
#(
  parameter int unsigned NUM_AXES  = 2,
  parameter int unsigned POS_W     = 16,
  parameter int unsigned CMD_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ui_in,
  output logic [7:0]       uo_out,
  neuro_odom_nch_if.slave  bus
);
  localparam int unsigned AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [2:0]          ctrl_q, ctrl_d;
  logic [POS_W-1:0]    thresh_q, thresh_d;
  logic [POS_W-2:0]    limit_q, limit_d;
  logic [8:0]          int_status_q, int_status_d, int_mask_q, int_mask_d;
  logic [CmdW-1:0]     fifo_q [CMD_DEPTH];
  logic [AW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]       count_q;
  logic [POS_W-1:0]    pos_q [NUM_AXES];
  logic [POS_W-1:0]    pos_d [NUM_AXES];
  logic [NUM_AXES-1:0] chg_q, chg_d;
  logic [7:0]          uo_d;
  logic [2*NUM_AXES-1:0] spike_rise;

  logic wr_en, wr_word, wr_cmd, clear, full, empty, push, pop, overflow, spk_on;
  logic [CmdW-1:0] head;
  logic unused_bus;

  assign unused_bus = ^{bus.data_read_n, ui_in};

  assign wr_en    = bus.data_write_n != WrNone;
  assign wr_word  = bus.data_write_n == WrWord;
  assign wr_cmd   = wr_word && (bus.address == AddrCmd);
  assign clear    = wr_en && (bus.address == AddrCtrl) && bus.data_in[CtrlClear];
  assign full     = count_q == CW'(CMD_DEPTH);
  assign empty    = count_q == '0;
  // A clear flushes the FIFO, so a push landing in the same cycle is discarded
  assign push     = wr_cmd && !full && !clear;
  assign pop      = ctrl_q[CtrlEnable] && !empty && !clear;
  assign overflow = wr_cmd && full;
  assign head     = fifo_q[rd_ptr_q];
  assign spk_on   = ctrl_q[CtrlEnable] && ctrl_q[CtrlSpikeEn];

  neuro_spike_sync #(
    .Width(2 * NUM_AXES)
  ) u_spike_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (ui_in[2*NUM_AXES-1:0]),
    .rise (spike_rise)
  );

  // Configuration register next-state, with byte/half/word merging
  always_comb begin
    ctrl_d     = ctrl_q;
    thresh_d   = thresh_q;
    limit_d    = limit_q;
    int_mask_d = int_mask_q;
    if (wr_en) begin
      if (bus.address == AddrCtrl)
        ctrl_d = 3'(wmerge(32'(ctrl_q), bus.data_in, bus.data_write_n));
      if (bus.address == AddrThresh)
        thresh_d = POS_W'(wmerge(32'(thresh_q), bus.data_in, bus.data_write_n));
      if (bus.address == AddrLimit)
        limit_d = (POS_W-1)'(wmerge(32'(limit_q), bus.data_in, bus.data_write_n));
      if (bus.address == AddrIntMask)
        int_mask_d = 9'(wmerge(32'(int_mask_q), bus.data_in, bus.data_write_n));
    end
  end

  // Per-axis position update, limit detection and threshold outputs
  always_comb begin
    logic signed [31:0] cur, delta, lim;
    int_status_d = int_status_q;
    if (wr_en && (bus.address == AddrIntStatus))
      int_status_d = int_status_q & ~9'(wmerge(32'd0, bus.data_in, bus.data_write_n));
    if (overflow) int_status_d[IntOverflow] = 1'b1;
    lim   = 32'($unsigned(limit_q));
    uo_d  = '0;
    chg_d = '0;
    cur   = '0;
    delta = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      cur   = {{(32-POS_W){pos_q[i][POS_W-1]}}, pos_q[i]};
      delta = '0;
      if (pop && (int'(head[CmdAxisMsb:CmdAxisLsb]) == i))
        delta = {{16{head[CmdDeltaMsb]}}, head[CmdDeltaMsb:0]};
      if (spk_on && spike_rise[2*i])   delta = delta + 32'sd1;
      if (spk_on && spike_rise[2*i+1]) delta = delta - 32'sd1;
      if (clear)
        pos_d[i] = '0;
      else if (wr_word && (bus.address == AddrPosBase + 6'(4 * i)))
        pos_d[i] = bus.data_in[POS_W-1:0];
      else if (ctrl_q[CtrlWrap])
        pos_d[i] = POS_W'(cur + delta);
      else
        pos_d[i] = POS_W'(sat_add(cur, delta, POS_W));
      chg_d[i] = pos_d[i] != pos_q[i];
      // Limit set is applied after W1C so a persisting condition wins
      if ((cur > lim) || (cur < -lim)) int_status_d[IntLimitLsb + i] = 1'b1;
      uo_d[i]     = $signed(pos_q[i]) >= $signed(thresh_q);
      uo_d[4 + i] = chg_q[i];
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= '0;
      thresh_q     <= '0;
      limit_q      <= '0;
      int_status_q <= '0;
      int_mask_q   <= '0;
      chg_q        <= '0;
      uo_out       <= '0;
      for (int i = 0; i < NUM_AXES; i++) pos_q[i] <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      thresh_q     <= thresh_d;
      limit_q      <= limit_d;
      int_status_q <= int_status_d;
      int_mask_q   <= int_mask_d;
      chg_q        <= chg_d;
      uo_out       <= uo_d;
      for (int i = 0; i < NUM_AXES; i++) pos_q[i] <= pos_d[i];
    end
  end

  // Command FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < CMD_DEPTH; i++) fifo_q[i] <= '0;
    end else if (clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.data_in[CmdW-1:0];
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Combinational read mux
  always_comb begin
    bus.data_out = '0;
    if (bus.address == AddrCmd)
      bus.data_out = {11'b0, 5'(count_q), 14'b0, full, empty};
    else if (bus.address == AddrCtrl)
      bus.data_out = 32'(ctrl_q);
    else if (bus.address == AddrThresh)
      bus.data_out = {{(32-POS_W){thresh_q[POS_W-1]}}, thresh_q};
    else if (bus.address == AddrLimit)
      bus.data_out = 32'(limit_q);
    else if (bus.address == AddrIntStatus)
      bus.data_out = 32'(int_status_q);
    else if (bus.address == AddrIntMask)
      bus.data_out = 32'(int_mask_q);
    for (int i = 0; i < NUM_AXES; i++)
      if (bus.address == AddrPosBase + 6'(4 * i))
        bus.data_out = {{(32-POS_W){pos_q[i][POS_W-1]}}, pos_q[i]};
  end

  assign bus.data_ready     = 1'b1;
  assign bus.user_interrupt = |(int_status_q & int_mask_q);
endmodule

// File: tb/tb_neuro_odom_nch.sv
// Directed bench for neuro_odom_nch with a queue-based scoreboard and monitor.
module tb_neuro_odom_nch;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  neuro_odom_nch_if bus ();

  neuro_odom_nch #(
    .NUM_AXES (2),
    .POS_W    (16),
    .CMD_DEPTH(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ui_in (ui_in),
    .uo_out(uo_out),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] A_CMD = 6'h00, A_CTRL = 6'h04, A_THR = 6'h08, A_LIM = 6'h0C;
  localparam logic [5:0] A_IST = 6'h10, A_IMSK = 6'h14, A_POS0 = 6'h20, A_POS1 = 6'h24;

  // Observation kinds: 0 = data_out, 1 = uo_out, 2 = user_interrupt, 3 = data_ready
  int          kind_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        chk = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Monitor: pops one expectation for every observation window the driver opens
  always @(negedge clk) begin
    if (chk) begin
      int          k;
      logic [31:0] e, act;
      string       nm;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got observation, expected queued entry");
      end else begin
        k  = kind_q.pop_front();
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        case (k)
          0:       act = bus.data_out;
          1:       act = {24'b0, uo_out};
          2:       act = {31'b0, bus.user_interrupt};
          default: act = {31'b0, bus.data_ready};
        endcase
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, e);
        end
      end
    end
  end

  task automatic observe(input int k, input logic [5:0] addr, input logic [31:0] e,
                         input string nm);
    if (k == 0) bus.address = addr;
    kind_q.push_back(k);
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk = 1'b1;
    @(posedge clk);
    #1;
    chk = 1'b0;
  endtask

  task automatic rd(input logic [5:0] addr, input logic [31:0] e, input string nm);
    observe(0, addr, e, nm);
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] d,
                    input logic [1:0] wn = 2'b10);
    bus.address      = addr;
    bus.data_in      = d;
    bus.data_write_n = wn;
    @(posedge clk);
    #1;
    bus.data_write_n = 2'b11;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    ui_in            = 8'h00;
    bus.address      = 6'h00;
    bus.data_in      = 32'h0;
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b11;
    idle(2);
    // Reset state
    observe(1, 6'h0, 32'h00, "reset_uo");
    observe(2, 6'h0, 32'h0, "reset_irq");
    rd(A_CMD, 32'h1, "reset_cmd_empty");
    rd(A_CTRL, 32'h0, "reset_ctrl");
    observe(3, 6'h0, 32'h1, "data_ready");
    rst_n = 1'b1;
    idle(2);

    // Spike path: +1 lands two edges after sampling, sustained high counts once
    wr(A_CTRL, 32'h5);
    ui_in = 8'h01;
    idle(1);
    idle(1);
    rd(A_POS0, 32'h0, "spike_latency_before");
    ui_in = 8'h00;
    rd(A_POS0, 32'h1, "spike_latency_at");
    observe(1, 6'h0, 32'h13, "uo_change_pulse");
    observe(1, 6'h0, 32'h03, "uo_pulse_once");
    idle(3);
    rd(A_POS0, 32'h1, "spike_sustained_once");
    ui_in = 8'h02;
    idle(3);
    ui_in = 8'h00;
    idle(3);
    rd(A_POS0, 32'h0, "spike_neg");

    // Commands to both axes and threshold outputs
    wr(A_CTRL, 32'h1);
    wr(A_CMD, 32'h0001_0064);
    wr(A_CMD, 32'h0000_FFF6);
    idle(3);
    rd(A_POS1, 32'd100, "cmd_pos1");
    rd(A_POS0, 32'hFFFF_FFF6, "cmd_pos0_neg");
    rd(A_CMD, 32'h1, "cmd_drained");
    wr(A_THR, 32'd50);
    idle(2);
    observe(1, 6'h0, 32'h02, "uo_thresh");

    // Saturate versus wrap
    wr(A_POS0, 32'h7FF0);
    wr(A_CMD, 32'h0000_0020);
    idle(3);
    rd(A_POS0, 32'h0000_7FFF, "saturate_hi");
    wr(A_CTRL, 32'h3);
    wr(A_POS0, 32'h7FF0);
    wr(A_CMD, 32'h0000_0020);
    idle(3);
    rd(A_POS0, 32'hFFFF_8010, "wrap");

    // FIFO held while disabled; fifth push overflows
    wr(A_CTRL, 32'h0);
    for (int i = 0; i < 5; i++) wr(A_CMD, 32'h0000_0001);
    rd(A_CMD, 32'h0004_0002, "fifo_full");
    rd(A_IST, 32'h0000_0103, "overflow_status");
    wr(A_IMSK, 32'h100);
    observe(2, 6'h0, 32'h1, "overflow_irq");
    wr(A_IST, 32'h100);
    observe(2, 6'h0, 32'h0, "overflow_w1c_irq");
    rd(A_IST, 32'h0000_0003, "overflow_w1c_status");

    // Clear flushes FIFO and positions
    wr(A_CTRL, 32'h8);
    rd(A_POS0, 32'h0, "clear_pos0");
    rd(A_POS1, 32'h0, "clear_pos1");
    rd(A_CMD, 32'h1, "clear_fifo");
    rd(A_CTRL, 32'h0, "clear_reads0");
    wr(A_LIM, 32'd1000);
    wr(A_IST, 32'h1FF);
    rd(A_IST, 32'h0, "status_cleared");

    // Limit interrupt, persistent set beats W1C
    wr(A_CTRL, 32'h1);
    wr(A_IMSK, 32'h2);
    wr(A_CMD, 32'h0001_03E9);
    idle(3);
    rd(A_IST, 32'h2, "limit_set");
    observe(2, 6'h0, 32'h1, "limit_irq");
    wr(A_IST, 32'h2);
    rd(A_IST, 32'h2, "limit_persist");
    wr(A_CMD, 32'h0001_FFFE);
    idle(2);
    wr(A_IST, 32'h2);
    rd(A_IST, 32'h0, "limit_at_boundary");
    observe(2, 6'h0, 32'h0, "limit_irq_clear");
    rd(A_POS1, 32'd999, "limit_pos1");

    // Same-cycle spike and command on axis 0
    wr(A_CTRL, 32'h5);
    rd(A_POS0, 32'h0, "combo_start");
    ui_in = 8'h01;
    idle(1);
    wr(A_CMD, 32'h0000_0005);
    rd(A_POS0, 32'h0, "combo_before");
    ui_in = 8'h00;
    rd(A_POS0, 32'h6, "combo_one_cycle");
    wr(A_CTRL, 32'h8);
    rd(A_POS0, 32'h0, "combo_clear_pos0");
    rd(A_POS1, 32'h0, "combo_clear_pos1");
    rd(A_CTRL, 32'h0, "combo_clear_ctrl");

    // Partial writes and unmapped read
    wr(A_THR, 32'h0000_1234);
    wr(A_THR, 32'hFFFF_FFAB, 2'b00);
    rd(A_THR, 32'h0000_12AB, "byte_write");
    wr(A_LIM, 32'hFFFF_0055, 2'b01);
    rd(A_LIM, 32'h0000_0055, "half_write");
    rd(6'h18, 32'h0, "unmapped");

    // Reset mid-operation discards pending commands
    wr(A_POS0, 32'h1234);
    wr(A_CMD, 32'h0000_0007);
    wr(A_CMD, 32'h0000_0007);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    rd(A_CMD, 32'h1, "midreset_fifo");
    rd(A_POS0, 32'h0, "midreset_pos0");
    rd(A_THR, 32'h0, "midreset_thresh");

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
